// File: rtl/ss_counter_pkg.sv
// Shared types and helpers for the loadable modulo counter.
// Mode constants, calculation width and load clamp.
package ss_counter_pkg;

  typedef enum logic [0:0] {
    SSC_WRAP = 1'b0,
    SSC_SAT  = 1'b1
  } ssc_mode_t;

  localparam int unsigned SSC_MAX_WIDTH = 16;
  localparam int unsigned SSC_CALC_W    = SSC_MAX_WIDTH + 1;

  function automatic logic [SSC_CALC_W-1:0] ssc_clamp(input logic [SSC_CALC_W-1:0] i_val,
                                                      input logic [SSC_CALC_W-1:0] i_max);
    return (i_val > i_max) ? i_max : i_val;
  endfunction

endpackage

// File: rtl/ss_counter_next.sv
// Combinational next-count, limit detect and terminal count for ss_counter_mod.
module ss_counter_next
  import ss_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned MODULUS = 1 << WIDTH,
  parameter ssc_mode_t   MODE    = SSC_WRAP
) (
  input  logic [WIDTH-1:0] i_out,
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_adv,
  input  logic             i_jmp,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_next,
  output logic             o_tc
);

  localparam logic [WIDTH:0] LIM_HI = (WIDTH + 1)'(MODULUS - 1);

  logic [WIDTH:0] w_cur;
  logic [WIDTH:0] w_lim;
  logic           w_at_lim;

  assign w_cur    = {1'b0, i_out};
  assign w_lim    = i_dir ? LIM_HI : '0;
  assign w_at_lim = (w_cur == w_lim);
  assign o_tc     = i_adv & ~i_jmp & w_at_lim;

  // Limit is compared before stepping, so a value >= MODULUS is never produced.
  always_comb begin
    o_next = i_out;
    if (i_jmp) begin
      o_next = WIDTH'(ssc_clamp(SSC_CALC_W'(i_in), SSC_CALC_W'(LIM_HI)));
    end else if (i_adv) begin
      if (!w_at_lim) begin
        o_next = i_dir ? WIDTH'(w_cur + 1'b1) : WIDTH'(w_cur - 1'b1);
      end else if (MODE == SSC_WRAP) begin
        o_next = i_dir ? '0 : WIDTH'(LIM_HI);
      end
    end
  end

endmodule

// File: rtl/ss_counter_mod.sv
// Parametrised loadable modulo counter: count and wrap-pulse flops around ss_counter_next.
module ss_counter_mod
  import ss_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned MODULUS = 1 << WIDTH,
  parameter ssc_mode_t   MODE    = SSC_WRAP
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_adv,
  input  logic             i_jmp,
  input  logic             i_dir,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_out,
  output logic             o_tc,
  output logic             o_wrap
);

  if (WIDTH < 2 || WIDTH > SSC_MAX_WIDTH) begin : g_bad_width
    $error("ss_counter_mod: WIDTH must be in 2..16");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("ss_counter_mod: MODULUS must be in 2..2**WIDTH");
  end

  logic [WIDTH-1:0] r_out;
  logic             r_wrap;
  logic [WIDTH-1:0] w_next;
  logic             w_tc;

  ss_counter_next #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS),
    .MODE   (MODE)
  ) u_next (
    .i_out (r_out),
    .i_in  (i_in),
    .i_adv (i_adv),
    .i_jmp (i_jmp),
    .i_dir (i_dir),
    .o_next(w_next),
    .o_tc  (w_tc)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_out  <= w_next;
      r_wrap <= w_tc & (MODE == SSC_WRAP);
    end
  end

  assign o_out  = r_out;
  assign o_tc   = w_tc;
  assign o_wrap = r_wrap;

endmodule

// File: tb/tb_ss_counter_mod.sv
// Self-checking bench for ss_counter_mod: vector table, corner sequences, random vs. model.
module tb_ss_counter_mod;
  import ss_counter_pkg::*;

  typedef struct {
    logic       jmp;
    logic       adv;
    logic       dir;
    logic [3:0] in;
    logic       tc;
    logic [3:0] out;
    logic       wrap;
  } vec_t;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 6-bit, modulus 64, wrap
  logic       a_adv, a_jmp, a_dir, a_tc, a_wrap;
  logic [5:0] a_in, a_out;
  // 4-bit, modulus 10, wrap
  logic       b_adv, b_jmp, b_dir, b_tc, b_wrap;
  logic [3:0] b_in, b_out;
  // 4-bit, modulus 10, saturate
  logic       s_adv, s_jmp, s_dir, s_tc, s_wrap;
  logic [3:0] s_in, s_out;
  // Two-stage BCD cascade
  logic       c_adv, c_jmp, c_dir, lo_tc, lo_wrap, hi_tc, hi_wrap;
  logic [3:0] c_in, lo_out, hi_out;

  ss_counter_mod #(.WIDTH(6), .MODULUS(64), .MODE(SSC_WRAP)) u_a (
    .i_clk(clk), .i_rst(rst), .i_adv(a_adv), .i_jmp(a_jmp), .i_dir(a_dir), .i_in(a_in),
    .o_out(a_out), .o_tc(a_tc), .o_wrap(a_wrap)
  );
  ss_counter_mod #(.WIDTH(4), .MODULUS(10), .MODE(SSC_WRAP)) u_b (
    .i_clk(clk), .i_rst(rst), .i_adv(b_adv), .i_jmp(b_jmp), .i_dir(b_dir), .i_in(b_in),
    .o_out(b_out), .o_tc(b_tc), .o_wrap(b_wrap)
  );
  ss_counter_mod #(.WIDTH(4), .MODULUS(10), .MODE(SSC_SAT)) u_s (
    .i_clk(clk), .i_rst(rst), .i_adv(s_adv), .i_jmp(s_jmp), .i_dir(s_dir), .i_in(s_in),
    .o_out(s_out), .o_tc(s_tc), .o_wrap(s_wrap)
  );
  ss_counter_mod #(.WIDTH(4), .MODULUS(10), .MODE(SSC_WRAP)) u_lo (
    .i_clk(clk), .i_rst(rst), .i_adv(c_adv), .i_jmp(c_jmp), .i_dir(c_dir), .i_in(c_in),
    .o_out(lo_out), .o_tc(lo_tc), .o_wrap(lo_wrap)
  );
  ss_counter_mod #(.WIDTH(4), .MODULUS(10), .MODE(SSC_WRAP)) u_hi (
    .i_clk(clk), .i_rst(rst), .i_adv(lo_tc), .i_jmp(c_jmp), .i_dir(c_dir), .i_in(c_in),
    .o_out(hi_out), .o_tc(hi_tc), .o_wrap(hi_wrap)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int jmp, input int adv, input int dir, input int in,
                              input int tc, input int out, input int wrap);
    vec_t v;
    v.jmp  = 1'(jmp);
    v.adv  = 1'(adv);
    v.dir  = 1'(dir);
    v.in   = 4'(in);
    v.tc   = 1'(tc);
    v.out  = 4'(out);
    v.wrap = 1'(wrap);
    return v;
  endfunction

  // Reference behaviour stated with modular arithmetic rather than limit compares.
  function automatic int unsigned mdl_next(input int unsigned cur, input int unsigned ld,
                                           input bit jmp, input bit adv, input bit dir,
                                           input int unsigned mod, input bit sat);
    if (jmp) return (ld < mod) ? ld : mod - 1;
    if (!adv) return cur;
    if (dir) return sat ? ((cur + 1 < mod) ? cur + 1 : mod - 1) : (cur + 1) % mod;
    return sat ? ((cur == 0) ? 0 : cur - 1) : (cur + mod - 1) % mod;
  endfunction

  function automatic bit mdl_tc(input int unsigned cur, input bit adv, input bit jmp,
                                input bit dir, input int unsigned mod);
    return adv && !jmp && (cur == (dir ? mod - 1 : 0));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    vec_t        vecs[$];
    int unsigned ma, mb, ms, na, nb, ns, hw;
    bit          ta, tb, ts;
    int          sat_up[4];
    int          sat_dn[3];

    rst = 1'b1;
    {a_adv, a_jmp, a_dir, a_in} = '0;
    {b_adv, b_jmp, b_dir, b_in} = '0;
    {s_adv, s_jmp, s_dir, s_in} = '0;
    {c_adv, c_jmp, c_dir, c_in} = '0;

    // Reset state and tc equation while held in reset
    #2;
    chk("rst_out", a_out, 0);
    chk("rst_wrap", a_wrap, 0);
    chk("rst_tc_idle", a_tc, 0);
    b_adv = 1'b1;
    b_dir = 1'b0;
    #1 chk("rst_tc_down", b_tc, 1);
    b_dir = 1'b1;
    #1 chk("rst_tc_up", b_tc, 0);
    b_adv = 1'b0;
    @(negedge clk) rst = 1'b0;
    tick();

    // Asynchronous reset mid-count
    a_jmp = 1'b1;
    a_in  = 6'd37;
    tick();
    a_jmp = 1'b0;
    chk("load37", a_out, 37);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", a_out, 0);
    chk("async_rst_wrap", a_wrap, 0);
    chk("async_rst_tc", a_tc, 0);
    @(negedge clk) rst = 1'b0;
    tick();

    // Asynchronous reset clears an active wrap pulse
    a_jmp = 1'b1;
    a_in  = 6'd63;
    tick();
    a_jmp = 1'b0;
    a_adv = 1'b1;
    a_dir = 1'b1;
    #1 chk("a_tc_63", a_tc, 1);
    tick();
    a_adv = 1'b0;
    chk("a_wrap_out", a_out, 0);
    chk("a_wrap_pulse", a_wrap, 1);
    #2 rst = 1'b1;
    #1 chk("async_rst_wrap_pulse", a_wrap, 0);
    @(negedge clk) rst = 1'b0;
    tick();

    // Vector table on the modulus-10 wrap counter
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 10; k++) vecs.push_back(mk(0, 1, 1, 0, int'(k == 9), (k + 1) % 10,
                                                   int'(k == 9)));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 2, 0, 2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 9, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8, 0));
    vecs.push_back(mk(1, 0, 1, 9, 0, 9, 0));
    vecs.push_back(mk(1, 1, 1, 4, 0, 4, 0));
    vecs.push_back(mk(1, 0, 1, 13, 0, 9, 0));
    vecs.push_back(mk(1, 1, 0, 15, 0, 9, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 9, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    foreach (vecs[i]) begin
      b_jmp = vecs[i].jmp;
      b_adv = vecs[i].adv;
      b_dir = vecs[i].dir;
      b_in  = vecs[i].in;
      #1 chk($sformatf("vec%0d_tc", i), b_tc, vecs[i].tc);
      tick();
      chk($sformatf("vec%0d_out", i), b_out, vecs[i].out);
      chk($sformatf("vec%0d_wrap", i), b_wrap, vecs[i].wrap);
    end
    b_adv = 1'b0;
    b_jmp = 1'b0;

    // Saturate mode up from 8, then down from 1
    sat_up = '{8, 9, 9, 9};
    sat_dn = '{1, 0, 0};
    s_jmp = 1'b1;
    s_in  = 4'd8;
    tick();
    s_jmp = 1'b0;
    s_adv = 1'b1;
    s_dir = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("sat_up%0d_out", k), s_out, sat_up[k]);
      chk($sformatf("sat_up%0d_tc", k), s_tc, int'(sat_up[k] == 9));
      chk($sformatf("sat_up%0d_wrap", k), s_wrap, 0);
      tick();
    end
    s_jmp = 1'b1;
    s_in  = 4'd1;
    tick();
    s_jmp = 1'b0;
    s_dir = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("sat_dn%0d_out", k), s_out, sat_dn[k]);
      chk($sformatf("sat_dn%0d_tc", k), s_tc, int'(sat_dn[k] == 0));
      chk($sformatf("sat_dn%0d_wrap", k), s_wrap, 0);
      tick();
    end
    s_adv = 1'b0;

    // Two-stage BCD cascade, 100 advances from 00
    c_jmp = 1'b1;
    c_in  = 4'd0;
    tick();
    c_jmp = 1'b0;
    c_adv = 1'b1;
    c_dir = 1'b1;
    hw    = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      chk($sformatf("bcd%0d_lo", i), lo_out, (i % 100) % 10);
      chk($sformatf("bcd%0d_hi", i), hi_out, (i % 100) / 10);
      if (hi_wrap) hw++;
      if (i == 99) begin
        chk("bcd99_lo_tc", lo_tc, 1);
        chk("bcd99_hi_tc", hi_tc, 1);
      end
    end
    chk("bcd_hi_wrap_count", hw, 1);
    c_adv = 1'b0;

    // Random stimulus against the reference model
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    ma = 0;
    mb = 0;
    ms = 0;
    for (int n = 0; n < 2000; n++) begin
      a_jmp = ($urandom_range(0, 7) == 0);
      a_adv = ($urandom_range(0, 3) != 0);
      a_dir = 1'($urandom_range(0, 1));
      a_in  = 6'($urandom_range(0, 63));
      b_jmp = ($urandom_range(0, 7) == 0);
      b_adv = ($urandom_range(0, 3) != 0);
      b_dir = 1'($urandom_range(0, 1));
      b_in  = 4'($urandom_range(0, 15));
      s_jmp = ($urandom_range(0, 7) == 0);
      s_adv = ($urandom_range(0, 3) != 0);
      s_dir = 1'($urandom_range(0, 1));
      s_in  = 4'($urandom_range(0, 15));
      #1;
      ta = mdl_tc(ma, a_adv, a_jmp, a_dir, 64);
      tb = mdl_tc(mb, b_adv, b_jmp, b_dir, 10);
      ts = mdl_tc(ms, s_adv, s_jmp, s_dir, 10);
      chk("rnd_a_tc", a_tc, ta);
      chk("rnd_b_tc", b_tc, tb);
      chk("rnd_s_tc", s_tc, ts);
      na = mdl_next(ma, a_in, a_jmp, a_adv, a_dir, 64, 1'b0);
      nb = mdl_next(mb, b_in, b_jmp, b_adv, b_dir, 10, 1'b0);
      ns = mdl_next(ms, s_in, s_jmp, s_adv, s_dir, 10, 1'b1);
      tick();
      ma = na;
      mb = nb;
      ms = ns;
      chk("rnd_a_out", a_out, ma);
      chk("rnd_b_out", b_out, mb);
      chk("rnd_s_out", s_out, ms);
      chk("rnd_a_wrap", a_wrap, ta);
      chk("rnd_b_wrap", b_wrap, tb);
      chk("rnd_s_wrap", s_wrap, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
